// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: 2-entry valid/ready skid buffer carrying ALU results
// and control, turning signed add/sub overflow into a precise trap with EPC capture.
module ex_mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic [2:0]       alu_ctr,
  input  logic [31:0]      store_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [31:0]      out_store_data,
  output logic [31:0]      out_pc,
  output logic             out_zero,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_trap,
  output logic [4:0]       out_rd,
  output logic [31:0]      epc,
  output logic             epc_valid,
  input  logic             exc_clr,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        trap;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, in_entry;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [31:0]      epc_q, epc_d;
  logic             epc_valid_q, epc_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, pop, trap_cond, trap_acc;

  // Only signed add/sub trap; unsigned and compare ops ignore the ALU flag.
  always_comb begin
    accept    = in_valid & in_ready_q;
    pop       = out_valid_q & out_ready;
    trap_cond = alu_overflow & ((alu_ctr == 3'b001) | (alu_ctr == 3'b101));
    trap_acc  = accept & trap_cond & ~flush;
    in_entry            = '0;
    in_entry.result     = alu_result;
    in_entry.zero       = alu_zero;
    in_entry.store_data = store_data;
    in_entry.rd         = rd;
    in_entry.reg_write  = reg_write & ~trap_cond;
    in_entry.mem_read   = mem_read & ~trap_cond;
    in_entry.mem_write  = mem_write & ~trap_cond;
    in_entry.trap       = trap_cond;
    in_entry.pc         = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      epc_q       <= '0;
      epc_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      epc_q       <= epc_d;
      epc_valid_q <= epc_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_entry;
        end
        ONE: begin
          if (accept && !pop) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (accept && pop) begin
            main_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);

    // A capture in the same cycle as an acknowledge wins over the clear.
    epc_d       = epc_q;
    epc_valid_d = epc_valid_q;
    if (trap_acc && (!epc_valid_q || exc_clr)) begin
      epc_d       = pc;
      epc_valid_d = 1'b1;
    end else if (exc_clr) begin
      epc_valid_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (trap_acc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    in_ready       = in_ready_q;
    out_valid      = out_valid_q;
    out_result     = main_q.result;
    out_zero       = main_q.zero;
    out_store_data = main_q.store_data;
    out_rd         = main_q.rd;
    out_reg_write  = main_q.reg_write;
    out_mem_read   = main_q.mem_read;
    out_mem_write  = main_q.mem_write;
    out_trap       = main_q.trap;
    out_pc         = main_q.pc;
    epc            = epc_q;
    epc_valid      = epc_valid_q;
    ovf_count      = cnt_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: per-cycle vector table plus hand sequences for
// backpressure, flush, and trap-counter saturation (counter built 2 bits wide).
module tb_ex_mem_stage;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready;
  logic [31:0] alu_result, store_data, pc;
  logic alu_zero, alu_overflow;
  logic [2:0] alu_ctr;
  logic [4:0] rd;
  logic reg_write, mem_read, mem_write;
  logic out_valid, out_ready;
  logic [31:0] out_result, out_store_data, out_pc, epc;
  logic out_zero, out_reg_write, out_mem_read, out_mem_write, out_trap, epc_valid;
  logic [4:0] out_rd;
  logic exc_clr;
  logic [CNT_W-1:0] ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_ctr(alu_ctr), .store_data(store_data), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_pc(out_pc), .out_zero(out_zero), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_trap(out_trap),
    .out_rd(out_rd), .epc(epc), .epc_valid(epc_valid), .exc_clr(exc_clr),
    .ovf_count(ovf_count)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  ctr;
    logic        ovf;
    logic        z;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] pc;
    logic [31:0] sd;
    logic        clr;
    logic        e_valid, e_trap, e_rw, e_mr, e_mw, e_z;
    logic [31:0] e_res, e_pc, e_sd, e_epc;
    logic [4:0]  e_rd;
    logic        e_ev;
    logic [1:0]  e_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; alu_result = 0; alu_zero = 0; alu_overflow = 0;
    alu_ctr = 0; store_data = 0; rd = 0; reg_write = 0; mem_read = 0;
    mem_write = 0; pc = 0; exc_clr = 0;
  endtask

  task automatic drive(input logic [2:0] ctr, input logic ovf, input logic [31:0] res,
                       input logic [31:0] p);
    in_valid = 1; alu_ctr = ctr; alu_overflow = ovf; alu_result = res; pc = p;
    reg_write = 1; rd = 5'd1; store_data = 32'h0; alu_zero = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; out_ready = 1;
    step(); step();
    rst = 0;
  endtask

  vec_t tbl [8];

  function automatic vec_t mk(logic iv, logic [2:0] ctr, logic ovf, logic z, logic [31:0] res,
      logic [4:0] r, logic rw, logic mr, logic mw, logic [31:0] p, logic [31:0] sd, logic clr,
      logic ev_o, logic et, logic erw, logic emr, logic emw, logic ez, logic [31:0] eres,
      logic [31:0] epc_o, logic [31:0] esd, logic [4:0] erd, logic [31:0] e_epc, logic e_ev,
      logic [1:0] ecnt);
    vec_t v;
    v.iv = iv; v.ctr = ctr; v.ovf = ovf; v.z = z; v.res = res; v.rd = r; v.rw = rw;
    v.mr = mr; v.mw = mw; v.pc = p; v.sd = sd; v.clr = clr;
    v.e_valid = ev_o; v.e_trap = et; v.e_rw = erw; v.e_mr = emr; v.e_mw = emw; v.e_z = ez;
    v.e_res = eres; v.e_pc = epc_o; v.e_sd = esd; v.e_rd = erd; v.e_epc = e_epc;
    v.e_ev = e_ev; v.e_cnt = ecnt;
    return v;
  endfunction

  initial begin
    //             iv ctr    ov z res           rd rw mr mw pc        sd       clr | val tr rw mr mw z res           pc        sd       rd epc       ev cnt
    tbl[0] = mk(1, 3'b001, 1, 0, 32'hEFFFFFFF, 5, 1, 0, 0, 32'h400, 32'h11, 0, 1, 1, 0, 0, 0, 0, 32'hEFFFFFFF, 32'h400, 32'h11, 5, 32'h400, 1, 1);
    tbl[1] = mk(1, 3'b000, 1, 0, 32'hEFFFFFFF, 5, 1, 0, 0, 32'h404, 32'h22, 0, 1, 0, 1, 0, 0, 0, 32'hEFFFFFFF, 32'h404, 32'h22, 5, 32'h400, 1, 1);
    tbl[2] = mk(1, 3'b010, 1, 0, 32'h1234,     0, 0, 1, 0, 32'h408, 32'h33, 0, 1, 0, 0, 1, 0, 0, 32'h1234,     32'h408, 32'h33, 0, 32'h400, 1, 1);
    tbl[3] = mk(1, 3'b101, 1, 1, 32'h80000000, 7, 0, 0, 1, 32'h40C, 32'h44, 0, 1, 1, 0, 0, 0, 1, 32'h80000000, 32'h40C, 32'h44, 7, 32'h400, 1, 2);
    tbl[4] = mk(1, 3'b001, 1, 0, 32'h7FFFFFFF, 9, 1, 0, 0, 32'h800, 32'h55, 1, 1, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 32'h800, 32'h55, 9, 32'h800, 1, 3);
    tbl[5] = mk(0, 3'b001, 1, 0, 32'h0,        0, 1, 0, 0, 32'hDEAD, 32'h0, 1, 0, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 32'h800, 32'h55, 9, 32'h800, 0, 3);
    tbl[6] = mk(1, 3'b111, 1, 0, 32'h1,        3, 1, 0, 0, 32'h900, 32'h66, 0, 1, 0, 1, 0, 0, 0, 32'h1,        32'h900, 32'h66, 3, 32'h800, 0, 3);
    tbl[7] = mk(1, 3'b001, 1, 0, 32'h5,        4, 1, 1, 0, 32'hA00, 32'h77, 0, 1, 1, 0, 0, 0, 0, 32'h5,        32'hA00, 32'h77, 4, 32'hA00, 1, 3);

    do_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_result", out_result, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_trap", {31'b0, out_trap}, 0);
    chk("rst_epc", epc, 0);
    chk("rst_epc_valid", {31'b0, epc_valid}, 0);
    chk("rst_count", {30'b0, ovf_count}, 0);

    // Table: out_ready held high, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      idle();
      in_valid = tbl[i].iv; alu_ctr = tbl[i].ctr; alu_overflow = tbl[i].ovf;
      alu_zero = tbl[i].z; alu_result = tbl[i].res; rd = tbl[i].rd;
      reg_write = tbl[i].rw; mem_read = tbl[i].mr; mem_write = tbl[i].mw;
      pc = tbl[i].pc; store_data = tbl[i].sd; exc_clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("v%0d_trap", i), {31'b0, out_trap}, {31'b0, tbl[i].e_trap});
      chk($sformatf("v%0d_rw", i), {31'b0, out_reg_write}, {31'b0, tbl[i].e_rw});
      chk($sformatf("v%0d_mr", i), {31'b0, out_mem_read}, {31'b0, tbl[i].e_mr});
      chk($sformatf("v%0d_mw", i), {31'b0, out_mem_write}, {31'b0, tbl[i].e_mw});
      chk($sformatf("v%0d_zero", i), {31'b0, out_zero}, {31'b0, tbl[i].e_z});
      chk($sformatf("v%0d_result", i), out_result, tbl[i].e_res);
      chk($sformatf("v%0d_pc", i), out_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_sd", i), out_store_data, tbl[i].e_sd);
      chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, tbl[i].e_rd});
      chk($sformatf("v%0d_epc", i), epc, tbl[i].e_epc);
      chk($sformatf("v%0d_epc_valid", i), {31'b0, epc_valid}, {31'b0, tbl[i].e_ev});
      chk($sformatf("v%0d_count", i), {30'b0, ovf_count}, {30'b0, tbl[i].e_cnt});
    end

    // Backpressure: A, B, C with out_ready low
    do_reset();
    out_ready = 0;
    drive(3'b000, 0, 32'hA, 32'h100); step();
    chk("bp_a_valid", {31'b0, out_valid}, 1);
    chk("bp_a_res", out_result, 32'hA);
    chk("bp_a_ready", {31'b0, in_ready}, 1);
    drive(3'b000, 0, 32'hB, 32'h104); step();
    chk("bp_b_res_held", out_result, 32'hA);
    chk("bp_b_ready", {31'b0, in_ready}, 0);
    drive(3'b000, 0, 32'hC, 32'h108); step();
    chk("bp_c_res_held", out_result, 32'hA);
    chk("bp_c_ready", {31'b0, in_ready}, 0);
    step();
    chk("bp_c_res_held2", out_result, 32'hA);
    out_ready = 1; step();
    chk("bp_rel_b", out_result, 32'hB);
    chk("bp_rel_ready", {31'b0, in_ready}, 1);
    step();
    chk("bp_rel_c", out_result, 32'hC);
    chk("bp_rel_c_valid", {31'b0, out_valid}, 1);
    idle(); step();
    chk("bp_drain", {31'b0, out_valid}, 0);

    // Flush in TWO and in EMPTY with trapping subs at the input
    do_reset();
    out_ready = 0;
    drive(3'b001, 1, 32'h1, 32'h400); step();
    drive(3'b000, 0, 32'h2, 32'h404); step();
    chk("fl_two_ready", {31'b0, in_ready}, 0);
    drive(3'b101, 1, 32'h3, 32'hC00); flush = 1; step();
    chk("fl_valid", {31'b0, out_valid}, 0);
    chk("fl_ready", {31'b0, in_ready}, 1);
    chk("fl_epc_valid", {31'b0, epc_valid}, 1);
    chk("fl_epc", epc, 32'h400);
    chk("fl_count", {30'b0, ovf_count}, 1);
    drive(3'b101, 1, 32'h4, 32'hD00); flush = 1; exc_clr = 1; step();
    chk("fl2_valid", {31'b0, out_valid}, 0);
    chk("fl2_count", {30'b0, ovf_count}, 1);
    chk("fl2_epc_valid", {31'b0, epc_valid}, 0);
    chk("fl2_epc", epc, 32'h400);

    // Counter saturation at 2 bits, then reset with an entry held
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 1, 32'h10 + i, 32'h2000 + 4 * i); step();
      chk($sformatf("sat_%0d", i), {30'b0, ovf_count}, (i < 3) ? i + 1 : 3);
    end
    idle(); rst = 1; step(); rst = 0;
    chk("rst2_valid", {31'b0, out_valid}, 0);
    chk("rst2_count", {30'b0, ovf_count}, 0);
    chk("rst2_trap", {31'b0, out_trap}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register between the execute stage (ALU) and the memory stage of the 32-bit MIPS-style datapath. It captures the ALU `Result`/`Zero`/`Overflow` outputs with their instruction control fields through a 2-entry valid/ready skid buffer. It converts signed-arithmetic overflow into a precise trap: the trapped instruction's register and memory writes are squashed and its PC is recorded. Sits directly downstream of the ALU and directly upstream of the data-memory stage.

## Interface
- `CNT_W`, 16, width of the saturating overflow-trap counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous pipeline flush
- `in_valid`  in  1  EX stage presents an instruction
- `in_ready`  out  1  stage can accept (registered)
- `alu_result`  in  32  ALU `Result`
- `alu_zero`  in  1  ALU `Zero`
- `alu_overflow`  in  1  ALU `Overflow`
- `alu_ctr`  in  3  ALU op: 000 addu, 001 add, 010 or, 100 subu, 101 sub, 110 sltu, 111 slt
- `store_data`  in  32  rt value for stores
- `rd`  in  5  destination register
- `reg_write`, `mem_read`, `mem_write`  in  1 each  control bits
- `pc`  in  32  instruction PC
- `out_valid`  out  1  entry presented to MEM
- `out_ready`  in  1  MEM accepts
- `out_result`, `out_store_data`, `out_pc`  out  32 each  registered payload
- `out_zero`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_trap`  out  1 each
- `out_rd`  out  5
- `epc`  out  32  PC of first unacknowledged trap
- `epc_valid`  out  1  trap pending
- `exc_clr`  in  1  acknowledge/clear pending trap
- `ovf_count`  out  CNT_W  saturating count of trapped instructions

## Operation
- Handshake: accept = `in_valid & in_ready`; pop = `out_valid & out_ready`. Payload must be held stable while `out_valid & !out_ready`.
- Storage: main entry (drives outputs) and skid entry. States EMPTY, ONE, TWO; `out_valid` = state != EMPTY; `in_ready` = state != TWO.
- EMPTY: accept -> ONE (main <= input).
- ONE: accept & !pop -> TWO (skid <= input); accept & pop -> ONE (main <= input); !accept & pop -> EMPTY; otherwise hold.
- TWO: pop -> ONE (main <= skid); otherwise hold. No accept is possible.
- Trap condition on accept: `alu_overflow & (alu_ctr == 001 | alu_ctr == 101)`. Overflow on addu, subu, or, sltu, or slt is ignored.
- Trapped entry is stored with `reg_write = mem_read = mem_write = 0` and `trap = 1`. Result, rd, pc, and zero are stored unchanged.
- EPC: on a trapping accept with `epc_valid = 0`: `epc <= pc`, `epc_valid <= 1`. Later traps do not overwrite `epc` and only increment the counter.
- `exc_clr`: `epc_valid <= 0`. If a trapping accept occurs in the same cycle, the capture wins: `epc <= pc`, `epc_valid` stays 1.
- `ovf_count`: +1 per trapping accept; saturates at all-ones.
- `flush`: state -> EMPTY, both entries invalidated. That cycle's input is discarded: no trap capture and no count. EPC and the counter are otherwise retained. `flush` overrides accept and pop.
- `rst` overrides everything.

## Timing
- Latency: 1 cycle. Input accepted at edge N appears on outputs after edge N when the stage was EMPTY, or when it was ONE with a simultaneous pop.
- Throughput: 1 instruction/cycle while `out_ready = 1`.
- `in_ready` is registered. It deasserts the cycle after the skid entry fills and reasserts the cycle after the first pop from TWO.
- Reset values: `out_valid = 0`, `in_ready = 1`, all payload outputs 0, `out_trap = 0`, `epc = 0`, `epc_valid = 0`, `ovf_count = 0`.
- Reset or flush with entries held: both entries lost; `out_valid = 0` the next cycle.
- No combinational path from any input to `in_ready`, `out_valid`, or the payload outputs.

## Test plan
- Add overflow: `alu_ctr = 001`, result 0xEFFFFFFF, overflow = 1, reg_write = 1, pc = 0x400 -> next cycle `out_trap = 1`, `out_reg_write = 0`, `epc = 0x400`, `epc_valid = 1`, `ovf_count = 1`.
- Unsigned pass-through: same operands with `alu_ctr = 000`, overflow = 1 -> `out_trap = 0`, `out_reg_write = 1`, `out_result = 0xEFFFFFFF`, count unchanged.
- Backpressure: `out_ready = 0`; issue instructions A, B, C on consecutive cycles -> A held on outputs, `in_ready = 0` after B; C is not accepted until ready returns. Release `out_ready` -> A, B, C emerge in order with no loss or duplication.
- Flush in TWO with a trapping sub (`alu_ctr = 101`) at the input -> `out_valid = 0` next cycle, `in_ready = 1`, `epc_valid` and `ovf_count` unchanged.
- Simultaneous `exc_clr` and trapping accept at pc 0x800 -> `epc = 0x800`, `epc_valid = 1`. `exc_clr` alone -> `epc_valid = 0`.
- Counter saturation: with `CNT_W = 2`, five trapping adds -> `ovf_count` reads 1, 2, 3, 3, 3.
